// File: rtl/VX_tb_common_pkg.sv
// VX_tb_common_pkg
// Shared RV32I decode types: field typedefs, the instruction-type enum
// (with an ILLEGAL member), major-opcode constants, the decoded-entry
// struct and the opcode classifier used by the field extractor.
package VX_tb_common_pkg;

  typedef logic [6:0]  opcode_t;
  typedef logic [4:0]  reg_idx_t;
  typedef logic [2:0]  funct3_t;
  typedef logic [6:0]  funct7_t;
  typedef logic [11:0] imm12_t;
  typedef logic [19:0] imm20_t;
  typedef logic [7:0]  imm8_t;
  typedef logic [6:0]  imm7_t;
  typedef logic [4:0]  imm5_t;

  // Encoding order doubles as the index into the per-type counters
  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5,
    ILLEGAL = 3'd6
  } risc_v_seq_inst_type_t;

  localparam int NUM_INST_TYPES = 7;

  localparam opcode_t OPC_OP     = 7'b0110011;
  localparam opcode_t OPC_OP_IMM = 7'b0010011;
  localparam opcode_t OPC_LOAD   = 7'b0000011;
  localparam opcode_t OPC_JALR   = 7'b1100111;
  localparam opcode_t OPC_SYSTEM = 7'b1110011;
  localparam opcode_t OPC_STORE  = 7'b0100011;
  localparam opcode_t OPC_BRANCH = 7'b1100011;
  localparam opcode_t OPC_LUI    = 7'b0110111;
  localparam opcode_t OPC_AUIPC  = 7'b0010111;
  localparam opcode_t OPC_JAL    = 7'b1101111;

  typedef struct packed {
    risc_v_seq_inst_type_t inst_type;
    opcode_t  opcode;
    reg_idx_t rd;
    funct3_t  funct3;
    reg_idx_t rs1;
    reg_idx_t rs2;
    funct7_t  funct7;
    imm12_t   i_type_imm;
    imm7_t    s_type_imm1;
    imm5_t    s_type_imm0;
    imm7_t    b_type_imm1;
    imm5_t    b_type_imm0;
    imm20_t   u_type_imm;
    imm12_t   j_type_imm1;
    imm8_t    j_type_imm0;
  } risc_v_dec_t;

  function automatic risc_v_seq_inst_type_t classify_opcode(input opcode_t op);
    case (op)
      OPC_OP:                                   return R_TYPE;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: return I_TYPE;
      OPC_STORE:                                return S_TYPE;
      OPC_BRANCH:                               return B_TYPE;
      OPC_LUI, OPC_AUIPC:                       return U_TYPE;
      OPC_JAL:                                  return J_TYPE;
      default:                                  return ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/VX_risc_v_inst_if.sv
// VX_risc_v_inst_if
// Decoded RV32I instruction fields. The decoder drives it through the
// master modport; consumers read it through the slave modport.
interface VX_risc_v_inst_if;
  import VX_tb_common_pkg::*;

  risc_v_seq_inst_type_t inst_type;
  opcode_t  opcode;
  reg_idx_t rd;
  funct3_t  funct3;
  reg_idx_t rs1;
  reg_idx_t rs2;
  funct7_t  funct7;
  imm12_t   i_type_imm;
  imm7_t    s_type_imm1;
  imm5_t    s_type_imm0;
  imm7_t    b_type_imm1;
  imm5_t    b_type_imm0;
  imm20_t   u_type_imm;
  imm12_t   j_type_imm1;
  imm8_t    j_type_imm0;

  modport master (output inst_type, opcode, rd, funct3, rs1, rs2, funct7,
                  i_type_imm, s_type_imm1, s_type_imm0, b_type_imm1,
                  b_type_imm0, u_type_imm, j_type_imm1, j_type_imm0);
  modport slave  (input  inst_type, opcode, rd, funct3, rs1, rs2, funct7,
                  i_type_imm, s_type_imm1, s_type_imm0, b_type_imm1,
                  b_type_imm0, u_type_imm, j_type_imm1, j_type_imm0);
endinterface

// File: rtl/vx_risc_v_inst_field_extract.sv
// vx_risc_v_inst_field_extract
// Purely combinational RV32I field slicer. Classifies the opcode and
// drives only the fields the instruction type uses; all others are 0.
// Ports:
//   i_inst  [31:0]        raw instruction word
//   o_dec   risc_v_dec_t  classified type plus extracted fields
module vx_risc_v_inst_field_extract
  import VX_tb_common_pkg::*;
(
  input  logic [31:0] i_inst,
  output risc_v_dec_t o_dec
);

  risc_v_seq_inst_type_t w_type;

  assign w_type = classify_opcode(i_inst[6:0]);

  always_comb begin
    o_dec           = '0;
    o_dec.inst_type = w_type;
    o_dec.opcode    = i_inst[6:0];
    case (w_type)
      R_TYPE: begin
        o_dec.rd     = i_inst[11:7];
        o_dec.funct3 = i_inst[14:12];
        o_dec.rs1    = i_inst[19:15];
        o_dec.rs2    = i_inst[24:20];
        o_dec.funct7 = i_inst[31:25];
      end
      I_TYPE: begin
        o_dec.rd         = i_inst[11:7];
        o_dec.funct3     = i_inst[14:12];
        o_dec.rs1        = i_inst[19:15];
        o_dec.i_type_imm = i_inst[31:20];
      end
      S_TYPE: begin
        o_dec.funct3      = i_inst[14:12];
        o_dec.rs1         = i_inst[19:15];
        o_dec.rs2         = i_inst[24:20];
        o_dec.s_type_imm1 = i_inst[31:25];
        o_dec.s_type_imm0 = i_inst[11:7];
      end
      B_TYPE: begin
        o_dec.funct3      = i_inst[14:12];
        o_dec.rs1         = i_inst[19:15];
        o_dec.rs2         = i_inst[24:20];
        o_dec.b_type_imm1 = i_inst[31:25];
        o_dec.b_type_imm0 = i_inst[11:7];
      end
      U_TYPE: begin
        o_dec.rd         = i_inst[11:7];
        o_dec.u_type_imm = i_inst[31:12];
      end
      J_TYPE: begin
        o_dec.rd          = i_inst[11:7];
        o_dec.j_type_imm1 = i_inst[31:20];
        o_dec.j_type_imm0 = i_inst[19:12];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vx_risc_v_inst_decoder.sv
// vx_risc_v_inst_decoder
// RV32I decoder with a 2-entry in-order output FIFO. Words are decoded
// on entry and the head entry is presented on inst_if. in_ready and
// out_valid come straight from registers (no combinational ready path).
// Optional per-type statistics counters: define VX_TB_INST_STATS_EN.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_data      raw instruction word offer
//   in_ready              FIFO not full
//   out_valid/out_ready   head entry handshake
//   inst_if               decoded head fields (0 when out_valid=0)
//   out_illegal           head entry has an unrecognised opcode
//   stat_count            saturating counters R,I,S,B,U,J,ILLEGAL (macro only)
module vx_risc_v_inst_decoder
  import VX_tb_common_pkg::*;
#(
  parameter int STAT_W = 16
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  VX_risc_v_inst_if.master inst_if,
  output logic        out_illegal
`ifdef VX_TB_INST_STATS_EN
  ,
  output logic [NUM_INST_TYPES-1:0][STAT_W-1:0] stat_count
`endif
);

  risc_v_dec_t w_dec;
  risc_v_dec_t w_head;
  risc_v_dec_t r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_count_nxt;

  vx_risc_v_inst_field_extract u_extract (
    .i_inst (in_data),
    .o_dec  (w_dec)
  );

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = r_out_valid && out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: ;
    endcase
  end

  // Stage boundary: FIFO control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != 2'd2);
      r_out_valid <= (w_count_nxt != 2'd0);
    end
  end

  // Stage boundary: FIFO storage (contents unreset; masked by out_valid)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  assign w_head    = r_out_valid ? r_mem[r_rd_ptr] : '0;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_illegal = r_out_valid && (w_head.inst_type == ILLEGAL);

  assign inst_if.inst_type   = w_head.inst_type;
  assign inst_if.opcode      = w_head.opcode;
  assign inst_if.rd          = w_head.rd;
  assign inst_if.funct3      = w_head.funct3;
  assign inst_if.rs1         = w_head.rs1;
  assign inst_if.rs2         = w_head.rs2;
  assign inst_if.funct7      = w_head.funct7;
  assign inst_if.i_type_imm  = w_head.i_type_imm;
  assign inst_if.s_type_imm1 = w_head.s_type_imm1;
  assign inst_if.s_type_imm0 = w_head.s_type_imm0;
  assign inst_if.b_type_imm1 = w_head.b_type_imm1;
  assign inst_if.b_type_imm0 = w_head.b_type_imm0;
  assign inst_if.u_type_imm  = w_head.u_type_imm;
  assign inst_if.j_type_imm1 = w_head.j_type_imm1;
  assign inst_if.j_type_imm0 = w_head.j_type_imm0;

`ifdef VX_TB_INST_STATS_EN
  logic [NUM_INST_TYPES-1:0][STAT_W-1:0] r_stat;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  // Stage boundary: statistics counters, counted at acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat <= '0;
    end else if (w_push) begin
      r_stat[w_dec.inst_type] <= sat_inc(r_stat[w_dec.inst_type]);
    end
  end

  assign stat_count = r_stat;
`endif

endmodule
